// File: rtl/slow_clock_pkg.sv
// rtl/slow_clock_pkg.sv - shared constants and types for the slow-clock receive path
package slow_clock_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEF_PW      = 26;
  localparam int DEF_TIMEOUT = CLK_HZ;

  typedef logic [DEF_PW-1:0] period_t;

endpackage

// File: rtl/slow_clock_sync_filter.sv
// rtl/slow_clock_sync_filter.sv - synchroniser chain plus consecutive-sample glitch filter
module slow_clock_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 1
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic slow_in,
  output logic level,
  output logic level_next
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_next;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
    end
  end

  // Any sample agreeing with the current level restarts the run of disagreeing samples.
  always_comb begin
    level_next = level;
    cnt_next   = cnt_q;
    if (synced == level) begin
      cnt_next = '0;
    end else if (cnt_q == CW'(FILTER - 1)) begin
      level_next = synced;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt_q <= '0;
    end else begin
      level <= level_next;
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: rtl/slow_clock_edge_receiver.sv
// rtl/slow_clock_edge_receiver.sv - slow-clock tick generator with period measurement and loss detection
module slow_clock_edge_receiver
  import slow_clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 1,
  parameter int PW          = DEF_PW,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          slow_in,
  output logic          tick,
  output logic [7:0]    edge_count,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          lost
);

  localparam logic [PW-1:0] G_MAX   = '1;
  localparam logic [PW-1:0] TIMEOUT_G = PW'(TIMEOUT);

  logic          level;
  logic          level_next;
  logic [PW-1:0] gap_q;
  logic          armed_q;

  slow_clock_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER)
  ) u_sync_filter (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .slow_in    (slow_in),
    .level      (level),
    .level_next (level_next)
  );

  // Tick is registered alongside the level flip so it lands in the same cycle the level rises.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else begin
      tick <= level_next & ~level;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (tick) begin
      gap_q <= PW'(1);
    end else if (gap_q != G_MAX) begin
      gap_q <= gap_q + 1'b1;
    end
  end

  // A tick always beats a simultaneous timeout; the first tick after reset or loss only arms.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      edge_count   <= 8'd0;
      period       <= '0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
      armed_q      <= 1'b0;
    end else if (tick) begin
      edge_count <= edge_count + 8'd1;
      if (armed_q) begin
        period       <= gap_q;
        period_valid <= 1'b1;
      end
      armed_q <= 1'b1;
      lost    <= 1'b0;
    end else if (gap_q == TIMEOUT_G) begin
      lost         <= 1'b1;
      period_valid <= 1'b0;
      armed_q      <= 1'b0;
    end
  end

endmodule
